// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Receive-side frame controller for the UART RX path. It enables the external
// edge/bit counter while a frame is in progress and majority-samples the
// synchronized serial line three times around the middle of each bit. It
// deserializes the data bits LSB first, checks the optional parity bit and the
// stop bit, and presents the received word with a one-cycle strobe.
//
// Ports:
//   CLK, RST      rising-edge clock, asynchronous active-high reset
//   RX_IN         serial line, already synchronized to CLK, idles high
//   PAR_EN        1 = a parity bit follows the data bits
//   PAR_TYP       0 = even parity, 1 = odd parity
//   Prescale      oversampling ratio (8, 16 or 32), stable during a frame
//   edge_count    position within the current bit (from the counter)
//   bit_count     index of the current bit within the frame, 0 = start bit
//   cnt_enable    counter enable; the counter clears while this is low
//   P_DATA        last good received word, LSB = first data bit received
//   data_valid    one-cycle strobe, P_DATA updated with a good frame
//   par_err       one-cycle strobe, parity mismatch on the completed frame
//   stp_err       one-cycle strobe, stop bit sampled as 0
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  input  logic [5:0]            edge_count,
  input  logic [3:0]            bit_count,
  output logic                  cnt_enable,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, next_state;

  logic [5:0] mid;
  logic       at_s0, at_s1, at_s2, bit_end, stop_point;
  logic       s0, s1, s2, majority;

  logic [DATA_WIDTH-1:0] shift_reg, shift_d;
  logic                  perr, perr_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  cnt_enable_d, data_valid_d, par_err_d, stp_err_d;
  logic [DATA_WIDTH-1:0] p_data_d;

  // Sample points straddle the bit centre; the stop decision is taken two
  // edges after the centre so the next start bit can be caught early.
  assign mid        = {1'b0, Prescale[5:1]};
  assign at_s0      = (edge_count == (mid - 6'd1));
  assign at_s1      = (edge_count == mid);
  assign at_s2      = (edge_count == (mid + 6'd1));
  assign stop_point = (edge_count == (mid + 6'd2));
  assign bit_end    = (edge_count == (Prescale - 6'd1));
  assign majority   = (s0 & s1) | (s1 & s2) | (s0 & s2);

  // Three-point sampling of the serial line within the current bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      if (at_s0) s0 <= RX_IN;
      if (at_s1) s1 <= RX_IN;
      if (at_s2) s2 <= RX_IN;
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and next-value logic for the frame datapath and outputs.
  always_comb begin
    next_state   = state;
    cnt_enable_d = cnt_enable;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
    p_data_d     = P_DATA;
    shift_d      = shift_reg;
    perr_d       = perr;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;

    case (state)
      IDLE: begin
        cnt_enable_d = 1'b0;
        if (!RX_IN) begin
          par_en_d     = PAR_EN;
          par_typ_d    = PAR_TYP;
          cnt_enable_d = 1'b1;
          next_state   = START;
        end
      end

      START: begin
        if (bit_end) begin
          if (!majority) begin
            next_state = DATA;
          end else begin
            // Start bit did not hold low: treat as a glitch.
            next_state   = IDLE;
            cnt_enable_d = 1'b0;
          end
        end
      end

      DATA: begin
        if (bit_end) begin
          shift_d = {majority, shift_reg[DATA_WIDTH-1:1]};
          if (bit_count == LAST_DATA_BIT)
            next_state = par_en_q ? PARITY : STOP;
        end
      end

      PARITY: begin
        if (bit_end) begin
          perr_d     = majority ^ (par_typ_q ? ~^shift_reg : ^shift_reg);
          next_state = STOP;
        end
      end

      STOP: begin
        if (stop_point) begin
          if (majority && !perr) begin
            p_data_d     = shift_reg;
            data_valid_d = 1'b1;
          end else begin
            par_err_d = perr;
            stp_err_d = ~majority;
          end
          perr_d       = 1'b0;
          cnt_enable_d = 1'b0;
          next_state   = IDLE;
        end
      end

      default: begin
        next_state   = IDLE;
        cnt_enable_d = 1'b0;
      end
    endcase
  end

  // Registered datapath and outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_enable <= 1'b0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      P_DATA     <= '0;
      shift_reg  <= '0;
      perr       <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
    end else begin
      cnt_enable <= cnt_enable_d;
      data_valid <= data_valid_d;
      par_err    <= par_err_d;
      stp_err    <= stp_err_d;
      P_DATA     <= p_data_d;
      shift_reg  <= shift_d;
      perr       <= perr_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl
// Self-checking bench for uart_rx_frame_ctrl. It models the upstream edge/bit
// counter, drives whole serial frames cycle by cycle from a vector table and
// from a few hand-written sequences, and checks strobe counts, strobe timing
// and P_DATA against values computed from the frame format.
module tb_uart_rx_frame_ctrl;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [5:0] edge_count;
  logic [3:0] bit_count;
  logic       cnt_enable;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .edge_count (edge_count),
    .bit_count  (bit_count),
    .cnt_enable (cnt_enable),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cycle index: at a falling edge, cyc names the cycle currently in progress.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Model of the upstream edge/bit counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (!cnt_enable) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (edge_count == (Prescale - 6'd1)) begin
      edge_count <= '0;
      bit_count  <= bit_count + 4'd1;
    end else begin
      edge_count <= edge_count + 6'd1;
    end
  end

  // Strobe monitor: counts pulses, remembers their timing and data, and
  // counts rule violations (long pulses, data_valid together with an error).
  int         dv_count = 0;
  int         pe_count = 0;
  int         se_count = 0;
  int         last_strobe_cyc = -1;
  int         violations = 0;
  int         dv_cyc_q[$];
  logic [7:0] dv_data_q[$];
  logic       prev_dv = 1'b0;
  logic       prev_pe = 1'b0;
  logic       prev_se = 1'b0;

  always @(negedge CLK) begin
    if (data_valid) begin
      dv_count++;
      dv_cyc_q.push_back(cyc);
      dv_data_q.push_back(P_DATA);
    end
    if (par_err) pe_count++;
    if (stp_err) se_count++;
    if (data_valid || par_err || stp_err) last_strobe_cyc = cyc;
    if (data_valid && (par_err || stp_err)) violations++;
    if ((data_valid && prev_dv) || (par_err && prev_pe) || (stp_err && prev_se)) violations++;
    prev_dv = data_valid;
    prev_pe = par_err;
    prev_se = stp_err;
  end

  typedef struct {
    int         prescale;
    logic       par_en;
    logic       par_typ;
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    int         exp_dv;
    int         exp_pe;
    int         exp_se;
    logic [7:0] exp_pdata;
  } frame_vec_t;

  int checks = 0;
  int fails  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drives one frame starting at the current falling edge. Bit k is held for
  // cycles t+k*P .. t+k*P+P-1; noise_off inverts the line for one cycle and
  // cut_off truncates the frame after that many cycles.
  task automatic applyStimulus(input frame_vec_t v, input int noise_off, input int cut_off,
                               output int t_start);
    logic [11:0] bits;
    int          k;
    int          p;
    p    = v.prescale;
    k    = v.par_en ? 10 : 9;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = v.data[i];
    if (v.par_en) bits[9] = v.par_bit;
    bits[k] = v.stop_bit;
    Prescale = 6'(p);
    PAR_EN   = v.par_en;
    PAR_TYP  = v.par_typ;
    t_start  = cyc;
    for (int off = 0; off < (k + 1) * p && off < cut_off; off++) begin
      RX_IN = bits[off / p] ^ (off == noise_off);
      @(negedge CLK);
    end
    RX_IN = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  frame_vec_t vecs[11];
  frame_vec_t hv;
  int         t0, t1;
  int         dv0, pe0, se0;
  int         k_bits;

  initial begin
    // Prescale, parity enable/type, data, parity bit, stop bit,
    // expected dv/pe/se pulse counts, expected P_DATA afterwards.
    vecs[0]  = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
    vecs[1]  = '{16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1, 0, 0, 8'h3C};
    vecs[2]  = '{16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 0, 1, 0, 8'h3C};
    vecs[3]  = '{16, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1, 0, 0, 8'h3C};
    vecs[4]  = '{16, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 0, 1, 0, 8'h3C};
    vecs[5]  = '{16, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 1, 0, 0, 8'h07};
    vecs[6]  = '{16, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1, 0, 1, 0, 8'h07};
    vecs[7]  = '{32, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 0, 0, 1, 8'h07};
    vecs[8]  = '{32, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1, 0, 0, 8'h5A};
    vecs[9]  = '{16, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 0, 1, 1, 8'h5A};
    vecs[10] = '{8,  1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1, 0, 0, 8'hFF};

    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    Prescale = 6'd8;
    RST      = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("reset cnt_enable", cnt_enable, 0);
    checkOutput("reset P_DATA", P_DATA, 0);
    checkOutput("reset data_valid", data_valid, 0);
    checkOutput("reset par_err", par_err, 0);
    checkOutput("reset stp_err", stp_err, 0);
    RST = 1'b0;
    idleCycles(4);
    checkOutput("idle cnt_enable", cnt_enable, 0);

    // Table-driven frames.
    for (int i = 0; i < 11; i++) begin
      dv0 = dv_count; pe0 = pe_count; se0 = se_count;
      applyStimulus(vecs[i], -1, 100000, t0);
      idleCycles(3 * vecs[i].prescale + 4);
      k_bits = vecs[i].par_en ? 10 : 9;
      checkOutput($sformatf("vec%0d data_valid pulses", i), dv_count - dv0, vecs[i].exp_dv);
      checkOutput($sformatf("vec%0d par_err pulses", i), pe_count - pe0, vecs[i].exp_pe);
      checkOutput($sformatf("vec%0d stp_err pulses", i), se_count - se0, vecs[i].exp_se);
      checkOutput($sformatf("vec%0d strobe cycle", i), last_strobe_cyc - t0,
                  k_bits * vecs[i].prescale + vecs[i].prescale / 2 + 4);
      checkOutput($sformatf("vec%0d P_DATA", i), P_DATA, vecs[i].exp_pdata);
    end

    // Single-sample noise on the centre sample of data bit 3 of 0x00.
    hv  = '{16, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1, 0, 0, 8'h00};
    dv0 = dv_count; pe0 = pe_count; se0 = se_count;
    applyStimulus(hv, 1 + 4 * 16 + 8, 100000, t0);
    idleCycles(60);
    checkOutput("noise data_valid pulses", dv_count - dv0, 1);
    checkOutput("noise error pulses", (pe_count - pe0) + (se_count - se0), 0);
    checkOutput("noise P_DATA", P_DATA, 8'h00);

    // Start glitch: line low for two cycles only, Prescale = 8.
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    dv0 = dv_count; pe0 = pe_count; se0 = se_count;
    t0 = cyc;
    RX_IN = 1'b0;
    @(negedge CLK);
    checkOutput("glitch cnt_enable t+1", cnt_enable, 1);
    @(negedge CLK);
    RX_IN = 1'b1;
    repeat (6) @(negedge CLK);
    checkOutput("glitch cnt_enable t+8", cnt_enable, 1);
    @(negedge CLK);
    checkOutput("glitch cnt_enable t+9", cnt_enable, 0);
    idleCycles(20);
    checkOutput("glitch no strobes", (dv_count - dv0) + (pe_count - pe0) + (se_count - se0), 0);
    hv = '{8, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1, 0, 0, 8'hFF};
    applyStimulus(hv, -1, 100000, t0);
    idleCycles(30);
    checkOutput("after glitch data_valid pulses", dv_count - dv0, 1);
    checkOutput("after glitch P_DATA", P_DATA, 8'hFF);
    checkOutput("after glitch strobe cycle", last_strobe_cyc - t0, 80);

    // Reset in the middle of data bit 4.
    hv  = '{8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 0, 0, 0, 8'h00};
    dv0 = dv_count; pe0 = pe_count; se0 = se_count;
    applyStimulus(hv, -1, 45, t0);
    checkOutput("mid-frame cnt_enable", cnt_enable, 1);
    RST = 1'b1;
    #1;
    checkOutput("async reset cnt_enable", cnt_enable, 0);
    checkOutput("async reset P_DATA", P_DATA, 0);
    checkOutput("async reset strobes", {29'd0, data_valid, par_err, stp_err}, 0);
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    idleCycles(40);
    checkOutput("after reset cnt_enable", cnt_enable, 0);
    checkOutput("after reset no strobes", (dv_count - dv0) + (pe_count - pe0) + (se_count - se0), 0);

    // Back-to-back 8N1 frames, next start bit right after the stop bit.
    hv  = '{8, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 1, 0, 0, 8'h12};
    dv0 = dv_count;
    applyStimulus(hv, -1, 100000, t0);
    hv  = '{8, 1'b0, 1'b0, 8'h34, 1'b0, 1'b1, 1, 0, 0, 8'h34};
    applyStimulus(hv, -1, 100000, t1);
    idleCycles(30);
    checkOutput("b2b data_valid pulses", dv_count - dv0, 2);
    if (dv_cyc_q.size() >= 2) begin
      checkOutput("b2b first strobe cycle", dv_cyc_q[dv_cyc_q.size()-2] - t0, 80);
      checkOutput("b2b first P_DATA", dv_data_q[dv_data_q.size()-2], 8'h12);
      checkOutput("b2b second strobe cycle", dv_cyc_q[dv_cyc_q.size()-1] - t1, 80);
      checkOutput("b2b second P_DATA", dv_data_q[dv_data_q.size()-1], 8'h34);
    end
    checkOutput("b2b final P_DATA", P_DATA, 8'h34);

    checkOutput("strobe rule violations", violations, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Receive-side frame controller for the UART RX path. It sits directly downstream of the edge/bit counter: it consumes `edge_count` and `bit_count` and drives the counter's enable. It also majority-samples the synchronized serial line, deserializes the data bits, checks parity and stop, and presents a parallel byte with a one-cycle valid strobe.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 5–12, so a full frame fits in the 4-bit `bit_count`.
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- RX_IN  in  1  serial line, already synchronized to CLK; idles high.
- PAR_EN  in  1  1 = a parity bit follows the data bits.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- Prescale  in  6  oversampling ratio; legal values 8, 16, 32. Must be stable while a frame is in progress.
- edge_count  in  6  from edge/bit counter; position within the current bit, 0..Prescale-1.
- bit_count  in  4  from edge/bit counter; index of the current bit within the frame (0 = start bit).
- cnt_enable  out  1  enable to the edge/bit counter; the counter clears while this is low.
- P_DATA  out  DATA_WIDTH  last good received word, LSB = first data bit received.
- data_valid  out  1  one-cycle strobe: P_DATA updated with a good frame.
- par_err  out  1  one-cycle strobe: parity mismatch on the completed frame.
- stp_err  out  1  one-cycle strobe: stop bit sampled as 0.

## Operation
- **Reset values:** state IDLE; cnt_enable, data_valid, par_err, stp_err = 0; P_DATA = 0; shift register, samples and latched config = 0.
- **Sample points:** mid = Prescale>>1.
  - s0, s1, s2 are registered when edge_count = mid-1, mid, mid+1 respectively.
  - Bit value = majority(s0, s1, s2), i.e. (s0&s1)|(s1&s2)|(s0&s2).
- **Bit-end event:** edge_count = Prescale-1.
- **Stop-decision event:** edge_count = mid+2. This is ≤ Prescale-1 for every legal Prescale.
- **IDLE**
  - cnt_enable = 0.
  - When RX_IN = 0 is sampled, latch PAR_EN and PAR_TYP, set cnt_enable = 1 and go to START.
- **START**
  - At bit-end with majority = 0, go to DATA.
  - At bit-end with majority = 1 (glitch), go to IDLE with cnt_enable = 0. No strobes are raised.
- **DATA**
  - At each bit-end, shift the majority bit in LSB-first (shift right, insert at the MSB).
  - At the bit-end where bit_count = DATA_WIDTH, go to PARITY if the latched PAR_EN = 1, otherwise go to STOP.
- **PARITY**
  - At bit-end, register perr = majority XOR expected.
  - expected = ^data for even parity, ~^data for odd parity.
  - Then go to STOP.
- **STOP** (at stop-decision)
  - serr = ~majority.
  - If serr = 0 and perr = 0: P_DATA <= shift register and data_valid <= 1.
  - Otherwise: par_err <= perr and stp_err <= serr; P_DATA holds its previous value.
  - Go to IDLE, cnt_enable <= 0, clear perr.
- **Parity disabled:** perr is always 0 and par_err never asserts.
- **Strobe clearing:** all strobes clear on the following cycle.
- **Reset mid-frame:** returns immediately to reset values. A partial frame is discarded with no strobes.

## Timing
- cnt_enable, strobes and P_DATA are registered; no combinational path from any input to any output.
- Let t = the cycle in which IDLE samples RX_IN = 0.
  - cnt_enable = 1 from t+1.
  - edge_count = 0 at t+1.
  - Bit k occupies cycles t+1+k·Prescale through t+k·Prescale+Prescale.
- Stop bit index K = 1 + DATA_WIDTH + PAR_EN.
  - Stop-decision cycle = t+1+K·Prescale+mid+2.
  - Strobes and P_DATA change in the following cycle.
  - Example, 8N1 with Prescale = 8: strobe at t+80.
- cnt_enable falls in the same cycle as the strobe. IDLE can detect a new start bit that same cycle, leaving a margin of roughly Prescale/2 - 3 cycles before the nominal stop-bit end for back-to-back frames.
- Glitch example, Prescale = 8: return to IDLE at t+9, cnt_enable = 0 at t+9.
- data_valid, par_err and stp_err are never asserted for more than one cycle. data_valid is never asserted together with either error.

## Test plan
- **8N1, Prescale = 8, byte 0xA5:** data_valid = 1 for exactly one cycle at t+80; P_DATA = 0xA5; par_err = stp_err = 0.
- **Parity, Prescale = 16, even parity:**
  - Byte 0x3C with parity bit 0 gives data_valid and P_DATA = 0x3C.
  - Next frame 0x3C with parity bit 1 gives par_err for one cycle, data_valid = 0, P_DATA remains 0x3C.
  - Repeat with odd parity and the inverted parity bit.
- **Stop bit 0, 8N1, Prescale = 32:** stp_err for one cycle, no data_valid; the next well-formed frame 0x5A is received correctly.
- **Start glitch, Prescale = 8:** RX_IN low for 2 cycles only. Returns to IDLE with cnt_enable = 0 at t+9; no strobes; a following frame 0xFF is received correctly.
- **Single-sample noise:** flip RX_IN at the edge_count = mid sample of data bit 3 of 0x00. The majority vote corrects it: P_DATA = 0x00, data_valid = 1.
- **Reset and back-to-back:**
  - Assert RST during data bit 4. All outputs go to 0 and the state returns to IDLE at once.
  - After release, two back-to-back 8N1 frames 0x12 and 0x34 (start bit immediately after the stop bit) give two data_valid pulses, with P_DATA = 0x12 then 0x34.
